// File: rtl/sub_seq_pkg.sv
// Shared definitions for the chunked sequential subtractor: FSM state
// encoding and the ceil-divide used to derive the slice count.
package sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit subtractor slice with borrow in/out.
module sub_chunk
    import sub_seq_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] w_full;

    always_comb begin
        w_full = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
        d      = w_full[CHUNK-1:0];
        bout   = w_full[CHUNK];
    end

endmodule

// File: rtl/sub_seq.sv
// Sequential subtractor: computes a - b - bin one CHUNK-bit slice per cycle,
// LSB first, with a valid/ready handshake on both sides.
module sub_seq
    import sub_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int HAS_BIN = 0,
    parameter int CHUNK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff
);

    localparam int N      = ceil_div(WIDTH, CHUNK);
    localparam int PW     = N * CHUNK;
    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam int LAST_W = WIDTH - (N - 1) * CHUNK;
    localparam logic [IW-1:0]    LAST_IDX  = IW'(N - 1);
    localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LAST_W);

    state_t          r_state;
    logic [PW-1:0]   r_a;
    logic [PW-1:0]   r_b;
    logic [PW-1:0]   r_res;
    logic            r_bin;
    logic            r_brw;
    logic [IW-1:0]   r_idx;

    logic            w_last;
    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_d;
    logic            w_cin;
    logic            w_bout;
    logic [PW-1:0]   w_a_pad;
    logic [PW-1:0]   w_b_pad;
    logic [PW-1:0]   w_d_pad;

    // Operands are shifted down each CALC cycle, so the active slice is always
    // the low CHUNK bits; the partial top slice is masked to its real width.
    always_comb begin
        w_last  = (r_idx == LAST_IDX);
        w_mask  = w_last ? LAST_MASK : '1;
        w_x     = r_a[CHUNK-1:0] & w_mask;
        w_y     = r_b[CHUNK-1:0] & w_mask;
        w_cin   = (r_idx == '0) ? r_bin : r_brw;
        w_a_pad = '0;
        w_a_pad[WIDTH-1:0] = a;
        w_b_pad = '0;
        w_b_pad[WIDTH-1:0] = b;
        w_d_pad = '0;
        w_d_pad[PW-1 -: CHUNK] = w_d & w_mask;
    end

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x    (w_x),
        .y    (w_y),
        .bin  (w_cin),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_brw   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= w_a_pad;
                        r_b     <= w_b_pad;
                        r_bin   <= (HAS_BIN != 0) ? bin : 1'b0;
                        r_brw   <= 1'b0;
                        r_idx   <= '0;
                        r_res   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_a   <= r_a >> CHUNK;
                    r_b   <= r_b >> CHUNK;
                    r_res <= (r_res >> CHUNK) | w_d_pad;
                    r_brw <= w_bout;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        diff      = out_valid ? {r_brw, r_res[WIDTH-1:0]} : '0;
    end

endmodule

// File: tb/tb_sub_seq.sv
// Directed and randomized checks of sub_seq across several WIDTH/CHUNK/HAS_BIN
// configurations; expected values come from the plain a-b-bin formula.
module tb_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] a_s;
    logic [32:0] b_s;
    logic        bin_s;
    logic [6:0]  iv;
    logic [6:0]  ordy;
    logic [6:0]  ir;
    logic [6:0]  ov;
    logic [33:0] d0, d1, d5, d6;
    logic [1:0]  d2;
    logic [8:0]  d3, d4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_seq #(.WIDTH(33), .HAS_BIN(0), .CHUNK(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s), .b(b_s),
        .bin(bin_s), .out_valid(ov[0]), .out_ready(ordy[0]), .diff(d0));
    sub_seq #(.WIDTH(33), .HAS_BIN(1), .CHUNK(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s), .b(b_s),
        .bin(bin_s), .out_valid(ov[1]), .out_ready(ordy[1]), .diff(d1));
    sub_seq #(.WIDTH(1), .HAS_BIN(1), .CHUNK(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[0:0]), .b(b_s[0:0]),
        .bin(bin_s), .out_valid(ov[2]), .out_ready(ordy[2]), .diff(d2));
    sub_seq #(.WIDTH(8), .HAS_BIN(1), .CHUNK(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a_s[7:0]), .b(b_s[7:0]),
        .bin(bin_s), .out_valid(ov[3]), .out_ready(ordy[3]), .diff(d3));
    sub_seq #(.WIDTH(8), .HAS_BIN(1), .CHUNK(8)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .a(a_s[7:0]), .b(b_s[7:0]),
        .bin(bin_s), .out_valid(ov[4]), .out_ready(ordy[4]), .diff(d4));
    sub_seq #(.WIDTH(33), .HAS_BIN(1), .CHUNK(1)) u5 (
        .clk(clk), .rst(rst), .in_valid(iv[5]), .in_ready(ir[5]), .a(a_s), .b(b_s),
        .bin(bin_s), .out_valid(ov[5]), .out_ready(ordy[5]), .diff(d5));
    sub_seq #(.WIDTH(33), .HAS_BIN(1), .CHUNK(33)) u6 (
        .clk(clk), .rst(rst), .in_valid(iv[6]), .in_ready(ir[6]), .a(a_s), .b(b_s),
        .bin(bin_s), .out_valid(ov[6]), .out_ready(ordy[6]), .diff(d6));

    function automatic int cfg_w(input int k);
        case (k)
            2:       return 1;
            3, 4:    return 8;
            default: return 33;
        endcase
    endfunction

    function automatic int cfg_c(input int k);
        case (k)
            2, 3, 5: return 1;
            6:       return 33;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_hb(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic logic [33:0] get_diff(input int k);
        case (k)
            0:       return d0;
            1:       return d1;
            2:       return 34'(d2);
            3:       return 34'(d3);
            4:       return 34'(d4);
            5:       return d5;
            default: return d6;
        endcase
    endfunction

    function automatic logic [33:0] model(input int w, input logic [32:0] av,
                                          input logic [32:0] bv, input logic bnv,
                                          input int hb);
        logic [63:0] aa, bb, r;
        aa = {31'b0, av} & ((64'd1 << w) - 64'd1);
        bb = {31'b0, bv} & ((64'd1 << w) - 64'd1);
        r  = aa - bb - ((hb != 0) ? {63'b0, bnv} : 64'd0);
        r  = r & ((64'd1 << (w + 1)) - 64'd1);
        return r[33:0];
    endfunction

    // Issue one operation on instance k, scramble the operands right after
    // acceptance, and report the accept-to-out_valid latency and the result.
    task automatic do_op(input int k, input logic [32:0] av, input logic [32:0] bv,
                         input logic bnv, output int lat, output logic [33:0] res);
        int n;
        @(negedge clk);
        a_s = av; b_s = bv; bin_s = bnv; iv[k] = 1'b1;
        n = 0;
        while (ir[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        iv[k] = 1'b0; a_s = ~av; b_s = ~bv; bin_s = ~bnv;
        lat = 0;
        res = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov[k] === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat != 0) res = get_diff(k);
        ordy[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = '0; ordy = '0; a_s = '0; b_s = '0; bin_s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (ir[k] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", k, ir[k]);
            end
            checks++;
            if (ov[k] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, ov[k]);
            end
            checks++;
            if (get_diff(k) !== 34'h0) begin
                errors++; $display("FAIL reset_diff[%0d] got %h want 0", k, get_diff(k));
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [33:0] res;
        do_op(0, 33'd5, 33'd3, 1'b0, lat, res);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        checks++;
        if (res !== 34'h0_0000_0002) begin
            errors++; $display("FAIL basic_diff got %h want 000000002", res);
        end
    endtask

    task automatic test_borrow();
        int lat;
        logic [33:0] res;
        do_op(0, 33'd0, 33'd1, 1'b0, lat, res);
        checks++;
        if (res !== 34'h3_FFFF_FFFF) begin
            errors++; $display("FAIL borrow_0m1 got %h want 3ffffffff", res);
        end
        do_op(0, 33'h1_0000_0000, 33'd1, 1'b0, lat, res);
        checks++;
        if (res !== 34'h0_FFFF_FFFF) begin
            errors++; $display("FAIL borrow_ripple got %h want 0ffffffff", res);
        end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL borrow_latency got %0d want 5", lat); end
        do_op(0, 33'h1_FFFF_FFFF, 33'd0, 1'b0, lat, res);
        checks++;
        if (res !== 34'h1_FFFF_FFFF) begin
            errors++; $display("FAIL borrow_max got %h want 1ffffffff", res);
        end
    endtask

    task automatic test_bin();
        int lat;
        logic [33:0] res;
        do_op(1, 33'd7, 33'd7, 1'b1, lat, res);
        checks++;
        if (res !== 34'h3_FFFF_FFFF) begin
            errors++; $display("FAIL bin_used got %h want 3ffffffff", res);
        end
        do_op(0, 33'd7, 33'd7, 1'b1, lat, res);
        checks++;
        if (res !== 34'h0) begin
            errors++; $display("FAIL bin_ignored got %h want 0", res);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a_s = 33'd100; b_s = 33'd1; bin_s = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov[0] === 1'b1) begin lat = i; break; end
        end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL bp_latency got %0d want 5", lat); end
        a_s = 33'd9; b_s = 33'd1; iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b1) begin
                errors++; $display("FAIL bp_hold_valid cyc%0d got %b want 1", i, ov[0]);
            end
            checks++;
            if (d0 !== 34'd99) begin
                errors++; $display("FAIL bp_hold_diff cyc%0d got %h want 063", i, d0);
            end
            checks++;
            if (ir[0] !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, ir[0]);
            end
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++; $display("FAIL bp_no_accept_on_consume in_ready got %b want 1", ir[0]);
        end
        checks++;
        if (ov[0] !== 1'b0) begin
            errors++; $display("FAIL bp_consumed out_valid got %b want 0", ov[0]);
        end
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov[0] === 1'b1) begin lat = i; break; end
        end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL bp_next_latency got %0d want 5", lat); end
        checks++;
        if (d0 !== 34'd8) begin errors++; $display("FAIL bp_next_diff got %h want 8", d0); end
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[0] = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [33:0] res;
        logic seen;
        @(negedge clk);
        a_s = 33'd50; b_s = 33'd8; bin_s = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        checks++;
        if (d0 !== 34'h0) begin errors++; $display("FAIL calc_diff_zero got %h want 0", d0); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ir[0] !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", ir[0]); end
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", ov[0]); end
        checks++;
        if (d0 !== 34'h0) begin errors++; $display("FAIL abort_diff got %h want 0", d0); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ov[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got %b want 0", seen); end
        do_op(0, 33'd50, 33'd8, 1'b0, lat, res);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL abort_next_latency got %0d want 5", lat); end
        checks++;
        if (res !== 34'd42) begin errors++; $display("FAIL abort_next_diff got %h want 2a", res); end
    endtask

    task automatic test_random();
        int w, c, hb, n, lat;
        logic [32:0] av, bv;
        logic bnv;
        logic [33:0] res, exp_d;
        for (int k = 0; k < 7; k++) begin
            w  = cfg_w(k);
            c  = cfg_c(k);
            hb = cfg_hb(k);
            n  = (w + c - 1) / c;
            for (int j = 0; j < 6; j++) begin
                case (j)
                    0:       begin av = '0; bv = '1; end
                    1:       begin av = '1; bv = '0; end
                    2:       begin av = '1; bv = '1; end
                    default: begin av = {$urandom, $urandom}; bv = {$urandom, $urandom}; end
                endcase
                bnv = (j < 3) ? 1'b1 : 1'($urandom_range(0, 1));
                do_op(k, av, bv, bnv, lat, res);
                exp_d = model(w, av, bv, bnv, hb);
                checks++;
                if (lat !== n) begin
                    errors++; $display("FAIL rand_latency k%0d j%0d got %0d want %0d", k, j, lat, n);
                end
                checks++;
                if (res !== exp_d) begin
                    errors++; $display("FAIL rand_diff k%0d j%0d a=%h b=%h bin=%b got %h want %h",
                                       k, j, av, bv, bnv, res, exp_d);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_bin();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_seq.md
SUB_SEQ -- requirements
Module: sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (>=1).
REQ-002 SHALL have parameter HAS_BIN, default 0, borrow-in enable (0: bin ignored, treated as 0).
REQ-003 SHALL have parameter CHUNK, default 8, bits processed per cycle (1..WIDTH).
REQ-004 SHALL have port clk input 1, single clock, all logic on rising edge.
REQ-005 SHALL have port rst input 1, reset that is synchronous and active-high.
REQ-006 SHALL have port in_valid input 1, operands present.
REQ-007 SHALL have port in_ready output 1, block can accept operands.
REQ-008 SHALL have port a input WIDTH, minuend, unsigned.
REQ-009 SHALL have port b input WIDTH, subtrahend, unsigned.
REQ-010 SHALL have port bin input 1, borrow-in, sampled only when HAS_BIN=1.
REQ-011 SHALL have port out_valid output 1, result present.
REQ-012 SHALL have port out_ready input 1, consumer accepts result.
REQ-013 SHALL have port diff output WIDTH+1, result.

Function
REQ-014 SHALL compute diff = (a - b - bin) mod 2^(WIDTH+1), with a and b zero-extended; diff[WIDTH] is the final borrow (1 when a < b+bin).
REQ-015 SHALL use FSM states IDLE, CALC, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-017 SHALL accept on in_valid&&in_ready: register a, b, bin (or 0), clear chunk index and borrow, then go IDLE->CALC.
REQ-018 SHALL subtract one CHUNK-bit slice per CALC cycle, LSB slice first, propagating borrow between slices through a borrow register.
REQ-019 SHALL, with N = ceil(WIDTH/CHUNK), process the last slice at width WIDTH-(N-1)*CHUNK when WIDTH is not a multiple of CHUNK; bits above WIDTH SHALL never affect the result.
REQ-020 SHALL go CALC->DONE after slice N-1, so out_valid rises exactly N cycles after the accepting edge.
REQ-021 SHALL hold diff stable and out_valid high in DONE until out_valid&&out_ready, then return to IDLE.
REQ-022 SHALL NOT accept a new operand in the cycle a result is consumed; the next accept occurs no earlier than the following cycle. Minimum issue interval is N+2 cycles.
REQ-023 SHALL ignore in_valid, a, b and bin outside IDLE; operand changes after acceptance SHALL NOT affect the result.
REQ-024 SHALL drive diff to 0 except in DONE.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE and clear operands, chunk index, borrow and result; in_ready=1, out_valid=0, diff=0 from the next cycle.
REQ-026 SHALL let rst take priority over every handshake; a reset during CALC or DONE SHALL abort the operation with no result emitted.

Structure
REQ-027 SHALL place the state enum (IDLE/CALC/DONE) in shared package sub_seq_pkg, together with a ceil-divide function used to derive N.
REQ-028 SHALL instantiate one sub-module, sub_chunk: combinational CHUNK-bit subtractor with inputs x, y, borrow-in and outputs d, borrow-out. Partial last slices SHALL be handled by masking its inputs.
REQ-029 SHALL size the chunk index counter as clog2(N) bits, minimum 1 bit.

Verification (WIDTH=33, CHUNK=8, N=5 unless stated)
REQ-030 SHALL cover a=5, b=3 accepted at edge t -> out_valid at t+5, diff=34'h0_0000_0002.
REQ-031 SHALL cover a=0, b=1 -> diff=34'h3_FFFF_FFFF (borrow set); a=33'h1_0000_0000, b=1 -> diff=34'h0_FFFF_FFFF, borrow ripples through all 5 slices including the 1-bit last slice.
REQ-032 SHALL cover HAS_BIN=1, a=7, b=7, bin=1 -> diff=34'h3_FFFF_FFFF; same stimulus with HAS_BIN=0 -> diff=0.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles in DONE -> diff and out_valid unchanged, in_ready=0, and a concurrent in_valid with a=9, b=1 is not accepted; after consumption, the next accept is at least 1 cycle later.
REQ-034 SHALL cover rst pulsed during the 3rd CALC cycle -> next cycle IDLE, in_ready=1, out_valid=0, diff=0; a new operation then completes correctly in 5 cycles.
REQ-035 SHALL cover random a, b, bin over WIDTH in {1,8,33} and CHUNK in {1,8,WIDTH} -> every diff matches the REQ-014 model at latency N.
